// File: rtl/regfile_onehot8_pkg.sv
// Shared sizes and the one-hot legality check for the register file.
// Also used by the write-select decoder's assertions.
package regfile_onehot8_pkg;

  localparam int NREG       = 8;
  localparam int ADDR_W     = 3;
  localparam int DATA_W_DFLT = 32;

  function automatic logic onehot_legal(input logic [NREG-1:0] sel);
    return $countones(sel) == 1;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: tracks registers with a pending writeback.
// Issue (set) beats writeback (clear) when both hit one index.
module regfile_scoreboard
  import regfile_onehot8_pkg::*;
#(
  parameter bit ZERO_REG = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_set_en,
  input  logic [ADDR_W-1:0] i_set_idx,
  input  logic [NREG-1:0]   i_clr,
  input  logic [ADDR_W-1:0] i_addr_a,
  input  logic [ADDR_W-1:0] i_addr_b,
  output logic              o_busy_a,
  output logic              o_busy_b
);

  logic [NREG-1:0] r_busy;
  logic [NREG-1:0] w_set;
  logic [NREG-1:0] w_busy_nxt;

  always_comb begin
    w_set = '0;
    if (i_set_en) w_set[i_set_idx] = 1'b1;
    w_busy_nxt = (r_busy & ~i_clr) | w_set;
    if (ZERO_REG) w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_busy <= '0;
    else        r_busy <= w_busy_nxt;
  end

  // A writeback landing this cycle releases the operand at once
  assign o_busy_a = r_busy[i_addr_a] & ~i_clr[i_addr_a];
  assign o_busy_b = r_busy[i_addr_b] & ~i_clr[i_addr_b];

endmodule

// File: rtl/regfile_onehot8.sv
// 8-entry register file with one-hot write port, bypassed reads,
// busy scoreboard and a sticky error for malformed write selects.
module regfile_onehot8
  import regfile_onehot8_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DFLT,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [NREG-1:0]   wr_sel,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              iss_en,
  input  logic [ADDR_W-1:0] iss_dst,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              busy_a,
  output logic              busy_b,
  output logic              err_onehot
);

  logic [DATA_W-1:0] r_regs [NREG];
  logic              r_err;
  logic              w_legal;
  logic [NREG-1:0]   w_wmask;
  logic              w_zero_a;
  logic              w_zero_b;

  assign w_legal = wr_en & onehot_legal(wr_sel);
  assign w_wmask = w_legal ? wr_sel : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++)
        if (w_wmask[i] && !(ZERO_REG && i == 0))
          r_regs[i] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             r_err <= 1'b0;
    else if (wr_en && !onehot_legal(wr_sel)) r_err <= 1'b1;
  end

  // Reset blanks reads even if a write is presented on the port
  assign w_zero_a = !rst_n || (ZERO_REG && rd_addr_a == '0);
  assign w_zero_b = !rst_n || (ZERO_REG && rd_addr_b == '0);

  assign rd_data_a = w_zero_a ? '0 :
                     w_wmask[rd_addr_a] ? wr_data : r_regs[rd_addr_a];
  assign rd_data_b = w_zero_b ? '0 :
                     w_wmask[rd_addr_b] ? wr_data : r_regs[rd_addr_b];

  assign err_onehot = r_err;

  regfile_scoreboard #(
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_set_en  (iss_en),
    .i_set_idx (iss_dst),
    .i_clr     (w_wmask),
    .i_addr_a  (rd_addr_a),
    .i_addr_b  (rd_addr_b),
    .o_busy_a  (busy_a),
    .o_busy_b  (busy_b)
  );

endmodule

// File: tb/tb_regfile_onehot8.sv
// Directed table, reset sequences and random traffic vs a reference model.
module tb_regfile_onehot8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [7:0]  wr_sel;
  logic [31:0] wr_data;
  logic        iss_en;
  logic [2:0]  iss_dst;
  logic [2:0]  rd_addr_a;
  logic [2:0]  rd_addr_b;
  logic [31:0] rd_data_a;
  logic [31:0] rd_data_b;
  logic        busy_a;
  logic        busy_b;
  logic        err_onehot;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_reg [8];
  logic        m_busy [8];
  logic        m_err;

  always #5 clk = ~clk;

  regfile_onehot8 #(
    .DATA_W   (32),
    .ZERO_REG (1'b1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_sel     (wr_sel),
    .wr_data    (wr_data),
    .iss_en     (iss_en),
    .iss_dst    (iss_dst),
    .rd_addr_a  (rd_addr_a),
    .rd_addr_b  (rd_addr_b),
    .rd_data_a  (rd_data_a),
    .rd_data_b  (rd_data_b),
    .busy_a     (busy_a),
    .busy_b     (busy_b),
    .err_onehot (err_onehot)
  );

  typedef struct {
    logic        we;
    logic [7:0]  sel;
    logic [31:0] d;
    logic        ie;
    logic [2:0]  dst;
    logic [2:0]  ra;
    logic [2:0]  rb;
    logic [31:0] ea;
    logic [31:0] eb;
    logic        eba;
    logic        ebb;
    logic        eerr;
  } vec_t;

  vec_t tbl [12];

  function automatic vec_t mk(logic we, logic [7:0] sel, logic [31:0] d,
                              logic ie, logic [2:0] dst,
                              logic [2:0] ra, logic [2:0] rb,
                              logic [31:0] ea, logic [31:0] eb,
                              logic eba, logic ebb, logic eerr);
    vec_t v;
    v.we = we; v.sel = sel; v.d = d; v.ie = ie; v.dst = dst;
    v.ra = ra; v.rb = rb; v.ea = ea; v.eb = eb;
    v.eba = eba; v.ebb = ebb; v.eerr = eerr;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(logic we, logic [7:0] sel, logic [31:0] d,
                       logic ie, logic [2:0] dst,
                       logic [2:0] ra, logic [2:0] rb);
    wr_en = we; wr_sel = sel; wr_data = d;
    iss_en = ie; iss_dst = dst;
    rd_addr_a = ra; rd_addr_b = rb;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_reg[i] = '0;
      m_busy[i] = 1'b0;
    end
    m_err = 1'b0;
  endtask

  function automatic int legal_idx();
    if (!wr_en || $countones(wr_sel) != 1) return -1;
    for (int i = 0; i < 8; i++) if (wr_sel[i]) return i;
    return -1;
  endfunction

  function automatic logic [31:0] exp_rd(logic [2:0] a);
    int w = legal_idx();
    if (a == 0) return '0;
    if (w == int'(a)) return wr_data;
    return m_reg[a];
  endfunction

  function automatic logic exp_busy(logic [2:0] a);
    return m_busy[a] && (legal_idx() != int'(a));
  endfunction

  task automatic model_step();
    int w = legal_idx();
    if (w > 0) begin
      m_reg[w] = wr_data;
      m_busy[w] = 1'b0;
    end
    if (iss_en && iss_dst != 0) m_busy[iss_dst] = 1'b1;
    if (wr_en && w < 0) m_err = 1'b1;
  endtask

  initial begin
    tbl[0]  = mk(1, 8'h08, 32'hDEADBEEF, 0, 0, 3, 0, 32'hDEADBEEF, 0, 0, 0, 0);
    tbl[1]  = mk(0, 8'h00, 32'h0,        0, 0, 3, 0, 32'hDEADBEEF, 0, 0, 0, 0);
    tbl[2]  = mk(0, 8'h00, 32'h0,        1, 5, 5, 3, 0, 32'hDEADBEEF, 0, 0, 0);
    tbl[3]  = mk(0, 8'h00, 32'h0,        0, 0, 5, 3, 0, 32'hDEADBEEF, 1, 0, 0);
    tbl[4]  = mk(1, 8'h20, 32'h5555AAAA, 0, 0, 5, 5, 32'h5555AAAA, 32'h5555AAAA, 0, 0, 0);
    tbl[5]  = mk(0, 8'h00, 32'h0,        0, 0, 5, 2, 32'h5555AAAA, 0, 0, 0, 0);
    tbl[6]  = mk(1, 8'h04, 32'h22222222, 1, 2, 2, 5, 32'h22222222, 32'h5555AAAA, 0, 0, 0);
    tbl[7]  = mk(0, 8'h00, 32'h0,        0, 0, 2, 5, 32'h22222222, 32'h5555AAAA, 1, 0, 0);
    tbl[8]  = mk(1, 8'h01, 32'hFFFFFFFF, 1, 0, 0, 1, 0, 0, 0, 0, 0);
    tbl[9]  = mk(0, 8'h00, 32'h0,        0, 0, 0, 3, 0, 32'hDEADBEEF, 0, 0, 0);
    tbl[10] = mk(1, 8'h06, 32'h00000001, 0, 0, 1, 2, 0, 32'h22222222, 0, 1, 0);
    tbl[11] = mk(0, 8'h00, 32'h0,        0, 0, 1, 2, 0, 32'h22222222, 0, 1, 1);

    drive(0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    check("reset_rd_a", rd_data_a, 0);
    check("reset_busy_a", {31'b0, busy_a}, 0);
    check("reset_err", {31'b0, err_onehot}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[k]) begin
      @(negedge clk);
      drive(tbl[k].we, tbl[k].sel, tbl[k].d, tbl[k].ie, tbl[k].dst,
            tbl[k].ra, tbl[k].rb);
      #1;
      check($sformatf("v%0d_rd_a", k), rd_data_a, tbl[k].ea);
      check($sformatf("v%0d_rd_b", k), rd_data_b, tbl[k].eb);
      check($sformatf("v%0d_busy_a", k), {31'b0, busy_a}, {31'b0, tbl[k].eba});
      check($sformatf("v%0d_busy_b", k), {31'b0, busy_b}, {31'b0, tbl[k].ebb});
      check($sformatf("v%0d_err", k), {31'b0, err_onehot}, {31'b0, tbl[k].eerr});
    end

    // Mid-traffic reset with a legal write and issue still presented
    @(negedge clk);
    #2 rst_n = 1'b0;
    for (int a = 0; a < 8; a++) begin
      drive(1, 8'(1 << a), 32'hA5A5A5A5, 1, 3'(a), 3'(a), 3'(a));
      #1;
      check($sformatf("inrst_rd_a%0d", a), rd_data_a, 0);
      check($sformatf("inrst_busy_a%0d", a), {31'b0, busy_a}, 0);
      check("inrst_err", {31'b0, err_onehot}, 0);
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    @(negedge clk);
    for (int a = 0; a < 8; a++) begin
      rd_addr_a = 3'(a);
      rd_addr_b = 3'(7 - a);
      #1;
      check($sformatf("postrst_rd_a%0d", a), rd_data_a, 0);
      check($sformatf("postrst_busy_b%0d", a), {31'b0, busy_b}, 0);
    end
    check("postrst_err", {31'b0, err_onehot}, 0);

    // Empty write select is also an error
    @(negedge clk);
    drive(1, 8'h00, 32'h12345678, 0, 0, 4, 0);
    #1 check("sel0_rd_a", rd_data_a, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 4, 0);
    #1 check("sel0_err", {31'b0, err_onehot}, 1);
    @(negedge clk);
    #1 check("sel0_err_hold", {31'b0, err_onehot}, 1);
    rst_n = 1'b0;
    #1 check("err_clr_rst", {31'b0, err_onehot}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    for (int n = 0; n < 500; n++) begin
      int r;
      logic [7:0] sel;
      @(negedge clk);
      r = $urandom_range(0, 39);
      if (r < 36)       sel = 8'(1 << (r % 8));
      else if (r == 36) sel = 8'h00;
      else              sel = 8'($urandom);
      drive(1'($urandom_range(0, 1)), sel, $urandom,
            1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
            3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
      #1;
      check("rnd_rd_a", rd_data_a, exp_rd(rd_addr_a));
      check("rnd_rd_b", rd_data_b, exp_rd(rd_addr_b));
      check("rnd_busy_a", {31'b0, busy_a}, {31'b0, exp_busy(rd_addr_a)});
      check("rnd_busy_b", {31'b0, busy_b}, {31'b0, exp_busy(rd_addr_b)});
      check("rnd_err", {31'b0, err_onehot}, {31'b0, m_err});
      model_step();
    end

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
